multicycle_control: RTL and testbench

Multicycle main control FSM for the 16-bit RISC core. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and latches the 4-bit opcode from fetched instructions. It drives the datapath enables and the 2-bit `ALUOp` consumed by `alu_control`, which turns `ALUOp` and `Opcode` into `ALU_Cnt`. A memory request/ready handshake stalls it on slow memory, and it counts retired instructions.

---
 rtl/risc_pkg.sv | 53 +++++
 rtl/ctrl_decode.sv | 57 +++++
 rtl/multicycle_control.sv | 118 +++++++++++
 tb/tb_multicycle_control.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared encodings for the 16-bit RISC control path: FSM states, opcodes, ALUOp codes
// and the control bundle. CTRL_ILLEGAL_TRAP_EN adds the TRAP state and the illegal strobe.
package risc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,S_TRAP  = 3'd5
`endif
  } state_t;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       jump;
    logic       bne;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= 4'h2) && (op <= 4'h9);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'hA) || (op >= 4'hE);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of FSM state + latched opcode (+ mem_ready in FETCH) into the
// datapath control bundle. Builds with or without CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode
  import risc_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        // IR and PC+2 are written only on the cycle the fetch completes.
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      S_DECODE: begin
        if (opcode == OP_JMP) begin
          ctrl.jump     = 1'b1;
          ctrl.pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_rtype(opcode)) begin
          ctrl.aluop = ALUOP_RTYPE;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          ctrl.aluop   = ALUOP_ADD;
          ctrl.alu_src = 1'b1;
        end else begin
          ctrl.aluop         = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.bne           = (opcode == OP_BNE);
        end
      end
      S_MEM: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = (opcode == OP_LD);
        ctrl.mem_write = (opcode == OP_ST);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (opcode != OP_LD);
        ctrl.mem_to_reg = (opcode == OP_LD);
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: ctrl.illegal = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: state register, opcode latch and retired-instruction counter.
// CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap (illegal port present) instead of acting as NOP.
module multicycle_control
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr_in,
  input  logic             mem_ready,
  output logic [3:0]       Opcode,
  output logic [1:0]       ALUOp,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             jump,
  output logic             bne,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] instr_count,
  output state_t           dbg_state
);

  // Memory handshake: mem_req stays high (with mem_read or mem_write) for as long as the
  // FSM sits in FETCH or MEM; the access completes on the first cycle mem_req && mem_ready.

  state_t     state, state_next;
  logic [3:0] opcode_q;
  ctrl_t      ctrl;

  // Only the opcode field of the fetched word is consumed by the control path.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_in[11:0];

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode_q == OP_JMP) begin
          state_next = S_FETCH;
        end else if (is_illegal(opcode_q)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = S_TRAP;
`else
          state_next = S_FETCH;
`endif
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_rtype(opcode_q))                         state_next = S_WB;
        else if (opcode_q == OP_LD || opcode_q == OP_ST) state_next = S_MEM;
        else                                            state_next = S_FETCH;
      end
      S_MEM: begin
        if (!mem_ready)             state_next = S_MEM;
        else if (opcode_q == OP_LD) state_next = S_WB;
        else                        state_next = S_FETCH;
      end
      S_WB:     state_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      opcode_q    <= 4'h0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && mem_ready) opcode_q <= instr_in[15:12];
      // Retirement is any return to FETCH from another state.
      if (state_next == S_FETCH && state != S_FETCH) instr_count <= instr_count + 1'b1;
    end
  end

  ctrl_decode u_decode (
    .state     (state),
    .opcode    (opcode_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign Opcode        = opcode_q;
  assign ALUOp         = ctrl.aluop;
  assign mem_req       = ctrl.mem_req;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign jump          = ctrl.jump;
  assign bne           = ctrl.bne;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src       = ctrl.alu_src;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal       = ctrl.illegal;
`endif
  assign dbg_state     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state/strobe/ALUOp checks with
// hand-computed vectors, reset behaviour, counter wrap and the illegal-opcode path.
module tb_multicycle_control;
  import risc_pkg::*;

  localparam int CNT_W = 8;

  // strobe vector order: mem_req mem_read mem_write ir_write | pc_write pc_write_cond jump bne
  //                      | reg_write reg_dst mem_to_reg alu_src
  localparam logic [11:0] F_WAIT  = 12'b1100_0000_0000;
  localparam logic [11:0] F_RDY   = 12'b1101_1000_0000;
  localparam logic [11:0] NONE    = 12'b0000_0000_0000;
  localparam logic [11:0] DEC_JMP = 12'b0000_1010_0000;
  localparam logic [11:0] EX_LS   = 12'b0000_0000_0001;
  localparam logic [11:0] EX_BNE  = 12'b0000_0101_0000;
  localparam logic [11:0] EX_BEQ  = 12'b0000_0100_0000;
  localparam logic [11:0] MEM_LD  = 12'b1100_0000_0000;
  localparam logic [11:0] MEM_ST  = 12'b1010_0000_0000;
  localparam logic [11:0] WB_R    = 12'b0000_0000_1100;
  localparam logic [11:0] WB_LD   = 12'b0000_0000_1010;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      instr_in;
  logic             mem_ready;
  logic [3:0]       Opcode;
  logic [1:0]       ALUOp;
  logic             mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic             jump, bne, reg_write, reg_dst, mem_to_reg, alu_src;
  logic [CNT_W-1:0] instr_count;
  state_t           dbg_state;
  logic [11:0]      strobes;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign strobes = {mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond,
                    jump, bne, reg_write, reg_dst, mem_to_reg, alu_src};

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .mem_ready     (mem_ready),
    .Opcode        (Opcode),
    .ALUOp         (ALUOp),
    .mem_req       (mem_req),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .jump          (jump),
    .bne           (bne),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src       (alu_src),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal       (illegal),
`endif
    .instr_count   (instr_count),
    .dbg_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply mem_ready, check the cycle's state/strobes/ALUOp, then advance one clock.
  task automatic cyc(input string tag, input logic rdy, input state_t st,
                     input logic [11:0] stb, input logic [1:0] aop);
    mem_ready = rdy;
    #1;
    check({tag, ".state"}, 32'(dbg_state), 32'(st));
    check({tag, ".strobes"}, 32'(strobes), 32'(stb));
    check({tag, ".aluop"}, 32'(ALUOp), 32'(aop));
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    instr_in = 16'h0000;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    #1;
    check("rst.state", 32'(dbg_state), 32'(S_FETCH));
    check("rst.strobes", 32'(strobes), 32'(F_WAIT));
    check("rst.opcode", 32'(Opcode), 32'h0);
    check("rst.count", 32'(instr_count), 32'h0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("rst.illegal", 32'(illegal), 32'h0);
`endif
    #1;

    // ADD, zero-wait: 4 cycles
    instr_in = 16'h2123;
    cyc("add.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    check("add.opcode", 32'(Opcode), 32'h2);
    cyc("add.d", 1'b0, S_DECODE, NONE, 2'b00);
    cyc("add.e", 1'b0, S_EXEC, NONE, 2'b10);
    cyc("add.w", 1'b0, S_WB, WB_R, 2'b00);
    check("add.count", 32'(instr_count), 32'h1);

    // LD with two MEM wait cycles: 7 cycles
    instr_in = 16'h0456;
    cyc("ld.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("ld.d", 1'b1, S_DECODE, NONE, 2'b00);
    cyc("ld.e", 1'b1, S_EXEC, EX_LS, 2'b00);
    cyc("ld.m0", 1'b0, S_MEM, MEM_LD, 2'b00);
    cyc("ld.m1", 1'b0, S_MEM, MEM_LD, 2'b00);
    cyc("ld.m2", 1'b1, S_MEM, MEM_LD, 2'b00);
    check("ld.opcode", 32'(Opcode), 32'h0);
    cyc("ld.w", 1'b0, S_WB, WB_LD, 2'b00);
    check("ld.count", 32'(instr_count), 32'h2);

    // ST then BNE then BEQ
    instr_in = 16'h1abc;
    cyc("st.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("st.d", 1'b0, S_DECODE, NONE, 2'b00);
    cyc("st.e", 1'b0, S_EXEC, EX_LS, 2'b00);
    cyc("st.m", 1'b1, S_MEM, MEM_ST, 2'b00);
    instr_in = 16'hc123;
    cyc("bne.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("bne.d", 1'b1, S_DECODE, NONE, 2'b00);
    cyc("bne.e", 1'b1, S_EXEC, EX_BNE, 2'b01);
    check("stbne.count", 32'(instr_count), 32'h4);
    instr_in = 16'hb000;
    cyc("beq.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("beq.d", 1'b0, S_DECODE, NONE, 2'b00);
    cyc("beq.e", 1'b0, S_EXEC, EX_BEQ, 2'b01);
    check("beq.count", 32'(instr_count), 32'h5);

    // JMP after a fetch wait; opcode must not load until the fetch completes
    instr_in = 16'hd00f;
    cyc("jmp.fw", 1'b0, S_FETCH, F_WAIT, 2'b00);
    check("jmp.opc_hold", 32'(Opcode), 32'hb);
    cyc("jmp.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    instr_in = 16'h2000;
    check("jmp.opc_d", 32'(Opcode), 32'hd);
    cyc("jmp.d", 1'b1, S_DECODE, DEC_JMP, 2'b00);
    check("jmp.count", 32'(instr_count), 32'h6);
    check("jmp.back", 32'(dbg_state), 32'(S_FETCH));

    // reset during WB beats the retirement increment
    instr_in = 16'h3000;
    cyc("rwb.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("rwb.d", 1'b0, S_DECODE, NONE, 2'b00);
    cyc("rwb.e", 1'b0, S_EXEC, NONE, 2'b10);
    rst = 1'b1;
    cyc("rwb.w", 1'b0, S_WB, WB_R, 2'b00);
    rst = 1'b0;
    check("rwb.count", 32'(instr_count), 32'h0);
    check("rwb.opcode", 32'(Opcode), 32'h0);

    // reset during an ST MEM wait
    instr_in = 16'h1000;
    cyc("rst_st.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("rst_st.d", 1'b0, S_DECODE, NONE, 2'b00);
    cyc("rst_st.e", 1'b0, S_EXEC, EX_LS, 2'b00);
    cyc("rst_st.m0", 1'b0, S_MEM, MEM_ST, 2'b00);
    rst = 1'b1;
    cyc("rst_st.m1", 1'b0, S_MEM, MEM_ST, 2'b00);
    rst = 1'b0;
    #1;
    check("rst_st.mem_write", 32'(mem_write), 32'h0);
    check("rst_st.count", 32'(instr_count), 32'h0);
    #1;
    cyc("rst_st.after", 1'b0, S_FETCH, F_WAIT, 2'b00);

    // illegal opcode 0xE
    instr_in = 16'he000;
    cyc("ill.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("ill.d", 1'b1, S_DECODE, NONE, 2'b00);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      cyc("ill.trap", 1'b1, S_TRAP, NONE, 2'b00);
      check("ill.flag", 32'(illegal), 32'h1);
    end
    check("ill.count", 32'(instr_count), 32'h0);
    do_reset();
    #1;
    check("ill.rst_flag", 32'(illegal), 32'h0);
    check("ill.rst_state", 32'(dbg_state), 32'(S_FETCH));
    #1;
`else
    check("ill.count", 32'(instr_count), 32'h1);
    instr_in = 16'hf000;
    cyc("illf.f", 1'b1, S_FETCH, F_RDY, 2'b00);
    cyc("illf.d", 1'b0, S_DECODE, NONE, 2'b00);
    check("illf.count", 32'(instr_count), 32'h2);
    do_reset();
`endif

    // counter wrap: 2^CNT_W zero-wait JMPs from reset
    instr_in = 16'hd000;
    for (int i = 0; i < (1 << CNT_W); i++) begin
      mem_ready = 1'b1;
      @(posedge clk);
      #2;
      mem_ready = 1'b0;
      @(posedge clk);
      #2;
      if (i == (1 << CNT_W) - 2) begin
        #1;
        check("wrap.max", 32'(instr_count), 32'hff);
        #1;
      end
    end
    #1;
    check("wrap.zero", 32'(instr_count), 32'h0);
    check("wrap.state", 32'(dbg_state), 32'(S_FETCH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
